// File: rtl/tlb_op_ctrl_if.sv
// Handshake between the MEM-stage TLB-op decoder and the TLB op controller.
// The master side presents the op; the slave side (controller) reports progress.
interface tlb_op_ctrl_if;
    logic       op_valid;
    logic [2:0] op_type;
    logic       cancel;
    logic       op_ready;
    logic       busy;
    logic       op_done;
    logic       refetch_req;

    modport master (
        output op_valid, op_type, cancel,
        input  op_ready, busy, op_done, refetch_req
    );

    modport slave (
        input  op_valid, op_type, cancel,
        output op_ready, busy, op_done, refetch_req
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR into the TLB array and writes the results back to CP0.
// Also owns CP0 Random and Wired.
//
//  state   | meaning
//  S_IDLE  | ready for a new op; Random free-runs
//  S_ISSUE | op presented to the TLB, results captured, Random held
//  S_WB    | CP0 write strobes / refetch request, op_done pulse
module tlb_op_ctrl #(
    parameter int TLB_LINE  = 32,
    parameter int TLB_WIDTH = 5
) (
    input  logic                clk,
    input  logic                resetn,
    tlb_op_ctrl_if.slave        op,
    input  logic [31:0]         index_in,
    input  logic                wired_we,
    input  logic [31:0]         wired_wdata,
    output logic [31:0]         wired_o,
    output logic [31:0]         random_o,
    output logic [2:0]          tlb_type,
    output logic [31:0]         tlb_index,
    output logic [31:0]         tlb_random,
    input  logic [31:0]         tlbp_index_i,
    input  logic [31:0]         tlbr_hi_i,
    input  logic [31:0]         tlbr_mask_i,
    input  logic [31:0]         tlbr_lo0_i,
    input  logic [31:0]         tlbr_lo1_i,
    output logic                index_we,
    output logic [31:0]         index_wdata,
    output logic                tlbr_we,
    output logic [31:0]         hi_wdata,
    output logic [31:0]         mask_wdata,
    output logic [31:0]         lo0_wdata,
    output logic [31:0]         lo1_wdata
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

    localparam logic [2:0] OP_TLBP  = 3'd1;
    localparam logic [2:0] OP_TLBR  = 3'd2;
    localparam logic [2:0] OP_TLBWI = 3'd3;
    localparam logic [2:0] OP_TLBWR = 3'd4;
    localparam logic [TLB_WIDTH-1:0] RAND_TOP = TLB_WIDTH'(TLB_LINE - 1);

    state_t                 state, state_nxt;
    logic [2:0]             op_q;
    logic [TLB_WIDTH:0]     idx_q;
    logic [TLB_WIDTH-1:0]   snap_q;
    logic [TLB_WIDTH-1:0]   random, wired;
    logic [31:0]            cap_index, cap_hi, cap_mask, cap_lo0, cap_lo1;
    logic                   accept;
    logic                   ready_c, done_c, refetch_c;

    // Only the low index bits matter; bit TLB_WIDTH is kept so out-of-range indices reach the TLB.
    logic unused_bits;
    assign unused_bits = ^{wired_wdata[31:TLB_WIDTH], index_in[31:TLB_WIDTH+1]};

    assign accept = (state == S_IDLE) && op.op_valid && !op.cancel &&
                    (op.op_type >= OP_TLBP) && (op.op_type <= OP_TLBWR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            idx_q  <= '0;
            snap_q <= '0;
        end else if (accept) begin
            op_q   <= op.op_type;
            idx_q  <= index_in[TLB_WIDTH:0];
            snap_q <= random;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_index <= '0;
            cap_hi    <= '0;
            cap_mask  <= '0;
            cap_lo0   <= '0;
            cap_lo1   <= '0;
        end else if (state == S_ISSUE) begin
            if (op_q == OP_TLBP) begin
                cap_index <= tlbp_index_i;
            end
            if (op_q == OP_TLBR) begin
                cap_hi   <= tlbr_hi_i;
                cap_mask <= tlbr_mask_i;
                cap_lo0  <= tlbr_lo0_i;
                cap_lo1  <= tlbr_lo1_i;
            end
        end
    end

    // Random wraps to the top once it reaches Wired, which also pins it when Wired >= top.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random <= RAND_TOP;
            wired  <= '0;
        end else if (wired_we) begin
            random <= RAND_TOP;
            wired  <= wired_wdata[TLB_WIDTH-1:0];
        end else if (state != S_ISSUE) begin
            random <= (random <= wired) ? RAND_TOP : random - 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        ready_c     = 1'b0;
        done_c      = 1'b0;
        refetch_c   = 1'b0;
        tlb_type    = 3'd0;
        tlb_index   = '0;
        tlb_random  = '0;
        index_we    = 1'b0;
        index_wdata = '0;
        tlbr_we     = 1'b0;
        hi_wdata    = '0;
        mask_wdata  = '0;
        lo0_wdata   = '0;
        lo1_wdata   = '0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tlb_type   = op_q;
                tlb_index  = (op_q == OP_TLBWR) ? 32'({1'b0, snap_q}) : 32'(idx_q);
                tlb_random = 32'(snap_q);
                state_nxt  = S_WB;
            end
            S_WB: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
                if (op_q == OP_TLBP) begin
                    index_we    = 1'b1;
                    index_wdata = cap_index;
                end
                if (op_q == OP_TLBR) begin
                    tlbr_we    = 1'b1;
                    hi_wdata   = cap_hi;
                    mask_wdata = cap_mask;
                    lo0_wdata  = cap_lo0;
                    lo1_wdata  = cap_lo1;
                end
                if ((op_q == OP_TLBWI) || (op_q == OP_TLBWR)) begin
                    refetch_c = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign op.op_ready    = ready_c;
    assign op.busy        = !ready_c;
    assign op.op_done     = done_c;
    assign op.refetch_req = refetch_c;
    assign random_o       = 32'(random);
    assign wired_o        = 32'(wired);
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed vector bench for tlb_op_ctrl: a per-cycle table from reset release,
// then hand-written sequences for Random/Wired wrap, TLBWR snapshot and mid-op reset.
module tb_tlb_op_ctrl;
    localparam logic [31:0] HI_C   = 32'hA5A5_1000;
    localparam logic [31:0] MASK_C = 32'h0001_E000;
    localparam logic [31:0] LO0_C  = 32'h0000_1234;
    localparam logic [31:0] LO1_C  = 32'h0000_5678;

    typedef struct {
        logic        ov;
        logic [2:0]  ot;
        logic        cn;
        logic [31:0] idx;
        logic        wwe;
        logic [31:0] wd;
        logic [31:0] pidx;
        logic        e_rdy;
        logic        e_done;
        logic        e_rf;
        logic [2:0]  e_type;
        logic [31:0] e_tidx;
        logic [31:0] e_trnd;
        logic        e_iwe;
        logic [31:0] e_iwd;
        logic        e_rwe;
        logic [31:0] e_rnd;
        logic [31:0] e_wir;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] index_in = '0;
    logic        wired_we = 1'b0;
    logic [31:0] wired_wdata = '0;
    logic [31:0] wired_o, random_o, tlb_index, tlb_random;
    logic [2:0]  tlb_type;
    logic [31:0] tlbp_index_i = '0;
    logic        index_we, tlbr_we;
    logic [31:0] index_wdata, hi_wdata, mask_wdata, lo0_wdata, lo1_wdata;

    int n_vec = 0;
    int n_err = 0;

    tlb_op_ctrl_if bus ();

    tlb_op_ctrl #(.TLB_LINE(32), .TLB_WIDTH(5)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .op           (bus.slave),
        .index_in     (index_in),
        .wired_we     (wired_we),
        .wired_wdata  (wired_wdata),
        .wired_o      (wired_o),
        .random_o     (random_o),
        .tlb_type     (tlb_type),
        .tlb_index    (tlb_index),
        .tlb_random   (tlb_random),
        .tlbp_index_i (tlbp_index_i),
        .tlbr_hi_i    (HI_C),
        .tlbr_mask_i  (MASK_C),
        .tlbr_lo0_i   (LO0_C),
        .tlbr_lo1_i   (LO1_C),
        .index_we     (index_we),
        .index_wdata  (index_wdata),
        .tlbr_we      (tlbr_we),
        .hi_wdata     (hi_wdata),
        .mask_wdata   (mask_wdata),
        .lo0_wdata    (lo0_wdata),
        .lo1_wdata    (lo1_wdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ov, input logic [2:0] ot, input logic cn, input logic [31:0] idx,
        input logic wwe, input logic [31:0] wd, input logic [31:0] pidx,
        input logic e_rdy, input logic e_done, input logic e_rf, input logic [2:0] e_type,
        input logic [31:0] e_tidx, input logic [31:0] e_trnd, input logic e_iwe,
        input logic [31:0] e_iwd, input logic e_rwe, input logic [31:0] e_rnd,
        input logic [31:0] e_wir);
        vec_t v;
        v.ov = ov; v.ot = ot; v.cn = cn; v.idx = idx; v.wwe = wwe; v.wd = wd; v.pidx = pidx;
        v.e_rdy = e_rdy; v.e_done = e_done; v.e_rf = e_rf; v.e_type = e_type;
        v.e_tidx = e_tidx; v.e_trnd = e_trnd; v.e_iwe = e_iwe; v.e_iwd = e_iwd;
        v.e_rwe = e_rwe; v.e_rnd = e_rnd; v.e_wir = e_wir;
        return v;
    endfunction

    // Idle cycle expectation with nothing presented.
    function automatic vec_t idle(input logic [31:0] rnd, input logic [31:0] wir);
        return mk(0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,0,0, rnd, wir);
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.op_valid = v.ov;
        bus.op_type  = v.ot;
        bus.cancel   = v.cn;
        index_in     = v.idx;
        wired_we     = v.wwe;
        wired_wdata  = v.wd;
        tlbp_index_i = v.pidx;
    endtask

    task automatic check(input string tag, input vec_t v);
        chk(tag, "op_ready",    32'(bus.op_ready),    32'(v.e_rdy));
        chk(tag, "busy",        32'(bus.busy),        32'(!v.e_rdy));
        chk(tag, "op_done",     32'(bus.op_done),     32'(v.e_done));
        chk(tag, "refetch_req", 32'(bus.refetch_req), 32'(v.e_rf));
        chk(tag, "tlb_type",    32'(tlb_type),        32'(v.e_type));
        chk(tag, "tlb_index",   tlb_index,            v.e_tidx);
        chk(tag, "tlb_random",  tlb_random,           v.e_trnd);
        chk(tag, "index_we",    32'(index_we),        32'(v.e_iwe));
        chk(tag, "index_wdata", index_wdata,          v.e_iwd);
        chk(tag, "tlbr_we",     32'(tlbr_we),         32'(v.e_rwe));
        chk(tag, "hi_wdata",    hi_wdata,             v.e_rwe ? HI_C   : 32'd0);
        chk(tag, "mask_wdata",  mask_wdata,           v.e_rwe ? MASK_C : 32'd0);
        chk(tag, "lo0_wdata",   lo0_wdata,            v.e_rwe ? LO0_C  : 32'd0);
        chk(tag, "lo1_wdata",   lo1_wdata,            v.e_rwe ? LO1_C  : 32'd0);
        chk(tag, "random_o",    random_o,             v.e_rnd);
        chk(tag, "wired_o",     wired_o,              v.e_wir);
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        check(tag, v);
    endtask

    vec_t vecs [21];

    initial begin
        //            ov ot cn idx           wwe wd            pidx           rdy dn rf ty tidx trnd iwe iwd            rwe rnd wir
        vecs[0]  = mk(0, 0, 0, 0,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 31, 0);
        vecs[1]  = mk(0, 0, 0, 0,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 30, 0);
        vecs[2]  = mk(1, 1, 0, 3,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 29, 0);
        vecs[3]  = mk(0, 0, 0, 0,            0, 0,            5,             0, 0, 0, 1, 3,   29, 0, 0,             0, 28, 0);
        vecs[4]  = mk(0, 0, 0, 0,            0, 0,            7,             0, 1, 0, 0, 0,   0,  1, 5,             0, 28, 0);
        vecs[5]  = mk(1, 1, 0, 0,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 27, 0);
        vecs[6]  = mk(0, 0, 0, 0,            0, 0,            32'h8000_0000, 0, 0, 0, 1, 0,   27, 0, 0,             0, 26, 0);
        vecs[7]  = mk(0, 0, 0, 0,            0, 0,            0,             0, 1, 0, 0, 0,   0,  1, 32'h8000_0000, 0, 26, 0);
        vecs[8]  = mk(1, 3, 1, 0,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 25, 0);
        vecs[9]  = mk(1, 5, 0, 0,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 24, 0);
        vecs[10] = mk(1, 2, 0, 32'h49,       0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 23, 0);
        vecs[11] = mk(0, 0, 1, 0,            0, 0,            0,             0, 0, 0, 2, 9,   23, 0, 0,             0, 22, 0);
        vecs[12] = mk(0, 0, 1, 0,            0, 0,            0,             0, 1, 0, 0, 0,   0,  0, 0,             1, 22, 0);
        vecs[13] = mk(1, 3, 0, 32'h8000_0025,0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 21, 0);
        vecs[14] = mk(1, 3, 0, 32'h8000_0025,0, 0,            0,             0, 0, 0, 3, 37,  21, 0, 0,             0, 20, 0);
        vecs[15] = mk(1, 3, 0, 32'h8000_0025,0, 0,            0,             0, 1, 1, 0, 0,   0,  0, 0,             0, 20, 0);
        vecs[16] = mk(1, 3, 0, 32'h8000_0025,0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 19, 0);
        vecs[17] = mk(0, 0, 0, 0,            0, 0,            0,             0, 0, 0, 3, 37,  19, 0, 0,             0, 18, 0);
        vecs[18] = mk(0, 0, 0, 0,            0, 0,            0,             0, 1, 1, 0, 0,   0,  0, 0,             0, 18, 0);
        vecs[19] = mk(0, 0, 0, 0,            1, 32'hFFFF_FFE4,0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 17, 0);
        vecs[20] = mk(0, 0, 0, 0,            0, 0,            0,             1, 0, 0, 0, 0,   0,  0, 0,             0, 31, 4);

        drive(idle(0, 0));
        repeat (3) @(negedge clk);
        #1;
        check("in_reset", idle(31, 0));
        resetn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), vecs[i]);
        end

        // Random counts down to Wired=4; TLBWR taken when Random reads 7.
        for (int r = 30; r >= 8; r--) step("rand_down", idle(r, 4));
        step("tlbwr_acc",   mk(1,4,0,0, 0,0,0, 1,0,0,0, 0,0,0,0,0, 7, 4));
        step("tlbwr_issue", mk(0,0,0,0, 0,0,0, 0,0,0,4, 7,7,0,0,0, 6, 4));
        step("tlbwr_wb",    mk(0,0,0,0, 0,0,0, 0,1,1,0, 0,0,0,0,0, 6, 4));
        step("rand_5",  idle(5, 4));
        step("rand_4",  idle(4, 4));
        step("rand_wrap", idle(31, 4));
        step("rand_30", idle(30, 4));

        // Wired at the top pins Random.
        step("wired31_we", mk(0,0,0,0, 1,32'd31,0, 1,0,0,0, 0,0,0,0,0, 29, 4));
        step("pin_a", idle(31, 31));
        step("pin_b", idle(31, 31));

        // Reset during ISSUE: no write-back for the aborted probe.
        step("rst_acc",   mk(1,1,0,2, 0,0,0, 1,0,0,0, 0,0,0,0,0, 31, 31));
        step("rst_issue", mk(0,0,0,0, 0,0,5, 0,0,0,1, 2,31,0,0,0, 31, 31));
        #2 resetn = 1'b0;
        #1;
        check("rst_async", idle(31, 0));
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_release", idle(31, 0));
        step("rst_post1", idle(30, 0));
        step("rst_post2", idle(29, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
